seg_display_mux: RTL and testbench

- Downstream consumer of the 8x16 register file's two read buses R and S; drives the board's 8-digit common-anode seven-segment display.
- Time-multiplexes 8 hex digits: digits 7..4 show R[15:0], digits 3..0 show S[15:0].
- Owns the refresh prescaler and exports the per-digit refresh tick.
- Snapshots R/S once per full scan so a displayed frame is always coherent.

---
 rtl/seg_display_mux_pkg.sv | 26 ++
 rtl/seg_display_mux_if.sv | 23 ++
 rtl/seg_display_mux_hex7seg.sv | 13 +
 rtl/seg_display_mux.sv | 120 ++++++++++++
 tb/tb_seg_display_mux.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_mux_pkg.sv
// Shared definitions for the seven-segment display multiplexer slice.
// Holds the active-low hex font, the "everything dark" constants and the
// scan state type used by seg_display_mux.
// No ports: package only.
package seg_pkg;

  // Segment pattern with every segment dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Anode pattern with every digit dark (active-low).
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  // Written MSB-first, so the leftmost entry is glyph F and the rightmost is glyph 0.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // BLANK until the first refresh tick after reset, then SCAN forever.
  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_display_mux_if.sv
// Bus between the register-file read side and the display multiplexer.
//   R, S : 16-bit register-file read buses (register-file side drives them)
//   en   : display enable, 0 blanks all anodes
//   an   : active-low digit anodes, one-hot when lit
//   seg  : active-low segments {g,f,e,d,c,b,a}
//   dp   : active-low decimal point
//   tick : one-cycle per-digit refresh strobe
// The master modport is the register-file/board side; the slave modport is the display block.
interface seg_display_mux_if;
  logic [15:0] R;
  logic [15:0] S;
  logic        en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        tick;

  modport master (output R, output S, output en,
                  input an, input seg, input dp, input tick);

  modport slave  (input R, input S, input en,
                  output an, output seg, output dp, output tick);
endinterface

// File: rtl/seg_display_mux_hex7seg.sv
// Combinational nibble to seven-segment lookup (active-low font).
//   nibble_i : 4-bit value to display
//   seg_o    : active-low segments {g,f,e,d,c,b,a}
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/seg_display_mux.sv
// Eight-digit time-multiplexed hex display of the register-file R and S buses.
// Digits 7..4 show R[15:0] and digits 3..0 show S[15:0]. Both buses are captured
// once per full scan, so a frame on the display always comes from one R/S pair.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low (0 = in reset)
//   bus   : slave side of seg_display_mux_if (R, S, en in; an, seg, dp, tick out)
// Parameters: CLK_HZ is the system clock rate and REFRESH_HZ the per-digit refresh
// rate. DIV = CLK_HZ/REFRESH_HZ must be at least 2.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 500
)(
  input  logic            clk,
  input  logic            reset,
  seg_display_mux_if.slave bus
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  scan_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      snapR_q, snapR_d;
  logic [15:0]      snapS_q, snapS_d;

  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [15:0]      digitWord;
  logic [3:0]       digitNibble;
  logic [6:0]       fontSeg;

  // The prescaler runs freely, whatever the state or enable, so ticks stay evenly spaced.
  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Advance the scan only on refresh ticks. The snapshot reloads at the start of
  // every frame: the first tick out of BLANK and each 7->0 wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snapR_d = snapR_q;
    snapS_d = snapS_q;
    if (tick) begin
      if (state_q == BLANK) begin
        state_d = SCAN;
        idx_d   = 3'd0;
        snapR_d = bus.R;
        snapS_d = bus.S;
      end else if (idx_q == 3'd7) begin
        idx_d   = 3'd0;
        snapR_d = bus.R;
        snapS_d = bus.S;
      end else begin
        idx_d   = idx_q + 3'd1;
      end
    end
  end

  // The digit is picked from the next idx and the next snapshot, so the registered
  // outputs change on the same edge as idx and add no latency.
  assign digitWord   = idx_d[2] ? snapR_d : snapS_d;
  assign digitNibble = digitWord[{idx_d[1:0], 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble_i (digitNibble),
    .seg_o    (fontSeg)
  );

  // Build the next display image. en only gates the anodes; the scan underneath keeps
  // running, so re-enabling resumes at the current digit.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == SCAN) begin
      seg_d = fontSeg;
      dp_d  = (idx_d != 3'd4);
      if (bus.en) begin
        an_d = ~(8'b0000_0001 << idx_d);
      end
    end
  end

  // All state and the output registers clear together on asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= BLANK;
      idx_q   <= 3'd0;
      snapR_q <= 16'h0000;
      snapS_q <= 16'h0000;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      snapR_q <= snapR_d;
      snapS_q <= snapS_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux with CLK_HZ=8 and REFRESH_HZ=2 (DIV=4).
// The reference model counts clock edges since reset release. It derives the tick
// count, the current digit and the frame capture points from that count with plain
// arithmetic, and uses its own copy of the hex font.
module tb_seg_display_mux;

  localparam int CLK_HZ     = 8;
  localparam int REFRESH_HZ = 2;
  localparam int DIV        = CLK_HZ / REFRESH_HZ;

  logic clk;
  logic reset;

  seg_display_mux_if bus ();

  seg_display_mux #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference font, active-low {g,f,e,d,c,b,a}.
  logic [6:0] fontRef [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  int          edgeCount = 0;
  bit          inReset   = 1'b1;
  logic        enLast    = 1'b0;
  logic [15:0] frameR    = 16'h0;
  logic [15:0] frameS    = 16'h0;

  // Compare one value, count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic modelEdge();
    int ticks;
    if (!inReset) begin
      edgeCount++;
      enLast = bus.en;
      if (edgeCount % DIV == 0) begin
        ticks = edgeCount / DIV;
        if ((ticks - 1) % 8 == 0) begin
          frameR = bus.R;
          frameS = bus.S;
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkAll();
    int ticks;
    int digit;
    logic [3:0] nib;
    logic [7:0] expAn;
    logic [6:0] expSeg;
    logic       expDp;
    logic       expTick;
    ticks   = edgeCount / DIV;
    expTick = !inReset && (edgeCount % DIV == DIV - 1);
    if (inReset || ticks == 0) begin
      expAn  = 8'hFF;
      expSeg = 7'h7F;
      expDp  = 1'b1;
    end else begin
      digit  = (ticks - 1) % 8;
      nib    = (digit >= 4) ? 4'((frameR >> (4 * (digit - 4))) & 16'hF)
                            : 4'((frameS >> (4 * digit)) & 16'hF);
      expSeg = fontRef[nib];
      expDp  = (digit == 4) ? 1'b0 : 1'b1;
      expAn  = enLast ? ~(8'h01 << digit) : 8'hFF;
    end
    checkOutput("an",   32'(bus.an),   32'(expAn));
    checkOutput("seg",  32'(bus.seg),  32'(expSeg));
    checkOutput("dp",   32'(bus.dp),   32'(expDp));
    checkOutput("tick", 32'(bus.tick), 32'(expTick));
  endtask

  // One clock: update the model at the edge, then check shortly after it.
  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic [15:0] s, input logic e);
    bus.R  = r;
    bus.S  = s;
    bus.en = e;
  endtask

  // Assert reset between clock edges, check that it acts at once, hold it, then release.
  task automatic pulseReset(input int holdCycles);
    #3;
    reset     = 1'b0;
    inReset   = 1'b1;
    edgeCount = 0;
    frameR    = 16'h0;
    frameS    = 16'h0;
    #1;
    checkAll();
    repeat (holdCycles) stepCycle();
    @(negedge clk);
    reset   = 1'b1;
    inReset = 1'b0;
  endtask

  logic [7:0] anSeq  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] segSeq [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

  initial begin
    int tickCount;
    int lastTick;
    reset = 1'b0;
    applyStimulus(16'h1234, 16'hABCD, 1'b1);

    // Held in reset for three cycles.
    $display("[TB] reset phase");
    repeat (3) stepCycle();
    @(negedge clk);
    reset   = 1'b1;
    inReset = 1'b0;

    // First tick, then a full scan against fixed patterns.
    $display("[TB] first frame");
    for (int t = 0; t < 8; t++) begin
      repeat (4) stepCycle();
      checkOutput("scanAn",  32'(bus.an),  32'(anSeq[t]));
      checkOutput("scanSeg", 32'(bus.seg), 32'(segSeq[t]));
      checkOutput("scanDp",  32'(bus.dp),  32'((t == 4) ? 1'b0 : 1'b1));
    end

    // R changes while digit 2 is shown: the current frame is unaffected.
    $display("[TB] mid-scan R change");
    repeat (12) stepCycle();
    applyStimulus(16'hFFFF, 16'hABCD, 1'b1);
    repeat (8) stepCycle();
    checkOutput("oldFrameSeg", 32'(bus.seg), 32'h19);
    checkOutput("oldFrameAn",  32'(bus.an),  32'hEF);
    repeat (32) stepCycle();
    checkOutput("newFrameSeg", 32'(bus.seg), 32'h0E);
    checkOutput("newFrameAn",  32'(bus.an),  32'hEF);

    // Enable dropped for six cycles; the scan keeps running underneath.
    $display("[TB] enable gap");
    applyStimulus(16'hFFFF, 16'hABCD, 1'b0);
    tickCount = 0;
    repeat (6) begin
      stepCycle();
      checkOutput("enOffAn", 32'(bus.an), 32'hFF);
      if (bus.tick) tickCount++;
    end
    checkOutput("enOffTicks", tickCount, 1);
    applyStimulus(16'hFFFF, 16'hABCD, 1'b1);
    stepCycle();
    checkOutput("enBackAn", 32'(bus.an), 32'hDF);

    // Asynchronous reset mid-scan.
    $display("[TB] async reset");
    pulseReset(2);
    for (int k = 1; k <= 4; k++) begin
      stepCycle();
      checkOutput("postRstTick", 32'(bus.tick), 32'((k == 3) ? 1 : 0));
    end
    checkOutput("postRstAn", 32'(bus.an), 32'hFE);

    // Tick spacing over forty cycles.
    $display("[TB] tick spacing");
    tickCount = 0;
    lastTick  = -1;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (bus.tick) begin
        tickCount++;
        if (lastTick >= 0) checkOutput("tickGap", i - lastTick, 4);
        lastTick = i;
      end
    end
    checkOutput("tickCount40", tickCount, 10);

    // Randomized traffic, occasional enable drops and resets.
    $display("[TB] random phase");
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      logic [15:0] s;
      logic        e;
      r = bus.R;
      s = bus.S;
      if ($urandom_range(0, 2) == 0) r = 16'($urandom);
      if ($urandom_range(0, 2) == 0) s = 16'($urandom);
      e = ($urandom_range(0, 9) != 0);
      applyStimulus(r, s, e);
      if ($urandom_range(0, 99) == 0) pulseReset($urandom_range(0, 3));
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
